aes_sbox_pipe: RTL and testbench

AES_SBOX_PIPE -- requirements
Module: aes_sbox_pipe

---
 rtl/aes_sbox_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_aes_sbox_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: three-stage, multi-lane AES S-box datapath built on
// composite-field arithmetic GF((2^4)^2).
//   stage 1: inverse affine (mode 01) and isomorphic map (modes 00/01)
//   stage 2: composite-field inversion (modes 00/01) or pass-through
//   stage 3: inverse map + affine (00), inverse map (01), forward map (10),
//            inverse map (11)
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input handshake; in_mode, in_data, in_tag payload
//   out_valid/out_ready     output handshake; out_data, out_tag payload
//   occupancy               number of valid stages (0..3)
// Field: GF(2^4) over x^4+x+1, extension y^2+y+lambda with lambda = 4'hC.
// Byte layout [7:4] = high coefficient, [3:0] = low coefficient.
module aes_sbox_pipe #(
    parameter int LANES = 4,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic [1:0]           occupancy
);

    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return p;
    endfunction

    // a^14 = a^-1 in GF(16); maps 0 to 0.
    function automatic logic [3:0] gf16_inv(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = gf16_mul(a, a);
        a4 = gf16_mul(a2, a2);
        a8 = gf16_mul(a4, a4);
        return gf16_mul(gf16_mul(a8, a4), a2);
    endfunction

    function automatic logic [7:0] gfc_mul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    // (h*y + l)^-1 = (h*d) y + (h+l)*d, with d = (h^2*lambda + h*l + l^2)^-1.
    function automatic logic [7:0] gfc_inv(input logic [7:0] a);
        logic [3:0] h, l, di;
        h  = a[7:4];
        l  = a[3:0];
        di = gf16_inv(gf16_mul(gf16_mul(h, h), LAMBDA) ^ gf16_mul(h, l) ^ gf16_mul(l, l));
        return {gf16_mul(h, di), gf16_mul(h ^ l, di)};
    endfunction

    // Linear map given as eight 8-bit columns; column i is the image of bit i.
    function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] x);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) r = r ^ cols[8*i +: 8];
        end
        return r;
    endfunction

    // Forward isomorphism: x (the AES generator) maps to the smallest
    // composite element beta that is a root of x^8+x^4+x^3+x+1; column i is beta^i.
    function automatic logic [63:0] iso_fwd_cols();
        logic [7:0]  beta, c8, c2, c3, c4, c8p;
        logic        found;
        logic [63:0] cols;
        beta  = 8'h00;
        found = 1'b0;
        for (int c = 0; c < 256; c++) begin
            c8  = 8'(c);
            c2  = gfc_mul(c8, c8);
            c3  = gfc_mul(c2, c8);
            c4  = gfc_mul(c2, c2);
            c8p = gfc_mul(c4, c4);
            if (!found && ((c8p ^ c4 ^ c3 ^ c8 ^ 8'h01) == 8'h00)) begin
                beta  = c8;
                found = 1'b1;
            end
        end
        cols       = '0;
        cols[7:0]  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            cols[8*i +: 8] = gfc_mul(cols[8*(i-1) +: 8], beta);
        end
        return cols;
    endfunction

    // Inverse columns: the preimage of each composite basis vector.
    function automatic logic [63:0] iso_inv_cols(input logic [63:0] fwd);
        logic [63:0] cols;
        logic [7:0]  y;
        cols = '0;
        for (int x = 0; x < 256; x++) begin
            y = lin_map(fwd, 8'(x));
            for (int j = 0; j < 8; j++) begin
                if (y == 8'(1 << j)) cols[8*j +: 8] = 8'(x);
            end
        end
        return cols;
    endfunction

    localparam logic [63:0] ISO_FWD = iso_fwd_cols();
    localparam logic [63:0] ISO_INV = iso_inv_cols(ISO_FWD);

    function automatic logic [7:0] affine_fwd(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8];
        end
        return b ^ 8'h63;
    endfunction

    function automatic logic [7:0] affine_inv(input logic [7:0] a);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            b[i] = a[(i+2)%8] ^ a[(i+5)%8] ^ a[(i+7)%8];
        end
        return b ^ 8'h05;
    endfunction

    function automatic logic [7:0] stage1_byte(input logic [1:0] m, input logic [7:0] b);
        case (m)
            2'b00:   return lin_map(ISO_FWD, b);
            2'b01:   return lin_map(ISO_FWD, affine_inv(b));
            default: return b;
        endcase
    endfunction

    function automatic logic [7:0] stage2_byte(input logic [1:0] m, input logic [7:0] b);
        return m[1] ? b : gfc_inv(b);
    endfunction

    function automatic logic [7:0] stage3_byte(input logic [1:0] m, input logic [7:0] b);
        case (m)
            2'b00:   return affine_fwd(lin_map(ISO_INV, b));
            2'b10:   return lin_map(ISO_FWD, b);
            default: return lin_map(ISO_INV, b);
        endcase
    endfunction

    logic                 v1, v2, v3;
    logic [1:0]           m1, m2, m3;
    logic [TAG_W-1:0]     t1, t2, t3;
    logic [8*LANES-1:0]   d1, d2, d3;
    logic [8*LANES-1:0]   s1_next, s2_next, s3_next;
    logic                 advance;

    // Whole pipeline moves together; only a held result at the output stalls it.
    assign advance   = !(v3 && !out_ready);
    assign in_ready  = rst_n && advance;
    assign out_valid = v3;
    assign out_data  = d3;
    assign out_tag   = t3;
    assign occupancy = {1'b0, v1} + {1'b0, v2} + {1'b0, v3};

    always_comb begin
        s1_next = '0;
        s2_next = '0;
        s3_next = '0;
        for (int k = 0; k < LANES; k++) begin
            s1_next[8*k +: 8] = stage1_byte(in_mode, in_data[8*k +: 8]);
            s2_next[8*k +: 8] = stage2_byte(m1, d1[8*k +: 8]);
            s3_next[8*k +: 8] = stage3_byte(m2, d2[8*k +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            m1 <= '0;
            m2 <= '0;
            m3 <= '0;
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
        end else if (advance) begin
            v1 <= in_valid;
            if (in_valid) begin
                m1 <= in_mode;
                t1 <= in_tag;
                d1 <= s1_next;
            end
            v2 <= v1;
            m2 <= m1;
            t2 <= t1;
            d2 <= s2_next;
            v3 <= v2;
            m3 <= m2;
            t3 <= t2;
            d3 <= s3_next;
        end
    end

    // m3 is kept so the mode travels with the result; it has no other use.
    logic unused_mode;
    assign unused_mode = ^m3;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Scoreboard bench for aes_sbox_pipe: a driver pushes reference results on
// acceptance, a separate monitor pops and compares on every output handshake.
module tb_aes_sbox_pipe;
    localparam int LANES = 4;
    localparam int TAG_W = 4;
    localparam int W     = 8 * LANES;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_mode = 2'b00;
    logic [W-1:0]     in_data = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [1:0]       occupancy;

    always #5 clk = ~clk;

    aes_sbox_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .occupancy(occupancy)
    );

    typedef struct packed {
        logic [W-1:0]     data;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t       sb_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] sbox [256];
    logic [7:0] isbox[256];
    logic [7:0] phi  [256];
    logic [7:0] phinv[256];

    // ---------------- reference model ----------------
    function automatic logic [7:0] aes_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [3:0] g16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (7'h13 << (i - 4));
        return p[3:0];
    endfunction

    // (ah*y+al)(bh*y+bl) with y^2 = y + 0xC
    function automatic logic [7:0] cmul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = g16_mul(a[7:4], b[7:4]);
        return {hh ^ g16_mul(a[7:4], b[3:0]) ^ g16_mul(a[3:0], b[7:4]),
                g16_mul(hh, 4'hC) ^ g16_mul(a[3:0], b[3:0])};
    endfunction

    task automatic build_tables();
        logic [7:0] inv, beta, p, pw, img;
        logic       found;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (aes_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) isbox[sbox[a]] = 8'(a);
        // beta: smallest composite root of the AES polynomial
        found = 1'b0;
        beta  = 8'h00;
        for (int c = 0; c < 256; c++) begin
            p  = 8'h01;
            pw = 8'h01;
            for (int e = 1; e <= 8; e++) begin
                pw = cmul(pw, 8'(c));
                if (e == 1 || e == 3 || e == 4 || e == 8) p = p ^ pw;
            end
            if (!found && p == 8'h00) begin
                beta  = 8'(c);
                found = 1'b1;
            end
        end
        for (int x = 0; x < 256; x++) begin
            img = 8'h00;
            pw  = 8'h01;
            for (int i = 0; i < 8; i++) begin
                if (x[i]) img = img ^ pw;
                pw = cmul(pw, beta);
            end
            phi[x] = img;
            phinv[img] = 8'(x);
        end
    endtask

    function automatic logic [W-1:0] ref_xform(input logic [1:0] m, input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int k = 0; k < LANES; k++) begin
            case (m)
                2'b00:   r[8*k +: 8] = sbox [d[8*k +: 8]];
                2'b01:   r[8*k +: 8] = isbox[d[8*k +: 8]];
                2'b10:   r[8*k +: 8] = phi  [d[8*k +: 8]];
                default: r[8*k +: 8] = phinv[d[8*k +: 8]];
            endcase
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired, got no completion, required completion", name);
    endtask

    initial begin : monitor
        logic             prev_stall;
        logic [W-1:0]     pd;
        logic [TAG_W-1:0] pt;
        exp_t             e;
        prev_stall = 1'b0;
        pd = '0;
        pt = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_data", 64'(out_data), 64'(pd));
                    check("hold_tag", 64'(out_tag), 64'(pt));
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        timeout_fail("unexpected_output");
                    end else begin
                        e = sb_q.pop_front();
                        check("out_data", 64'(out_data), 64'(e.data));
                        check("out_tag", 64'(out_tag), 64'(e.tag));
                    end
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data;
                pt = out_tag;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [1:0] m, input logic [W-1:0] d,
                         input logic [TAG_W-1:0] t, input logic ordy,
                         input logic [W-1:0] exp_d, output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_mode   = m;
        in_data   = d;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (acc) begin
            e.data = exp_d;
            e.tag  = t;
            sb_q.push_back(e);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [W-1:0] d,
                        input logic [TAG_W-1:0] t, input logic [W-1:0] exp_d);
        logic acc;
        int   guard;
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 200) begin
            drive(1'b1, m, d, t, 1'b1, exp_d, acc);
            guard++;
        end
        if (!acc) timeout_fail("send");
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00, '0, '0, 1'b1, '0, acc);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 500) begin
            idle(1);
            guard++;
        end
        check("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic         acc;
        logic         ordy;
        logic [W-1:0] d, din, dexp;
        int           sent, guard;
        logic [7:0]   x;

        build_tables();

        // reset state, including a request presented during reset
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // known vectors with fixed expected values and 3-cycle latency
        send(2'b00, 32'h5300_01FF, 4'h5, 32'hED63_7C16);
        for (int c = 1; c <= 3; c++) begin
            idle(1);
            check($sformatf("latency_c%0d", c), 64'(out_valid), (c == 3) ? 64'd1 : 64'd0);
        end
        send(2'b01, 32'hED63_7C16, 4'hA, 32'h5300_01FF);
        drain();

        // full sweeps: every lane sees every byte, for each mode
        for (int m = 0; m < 3; m++) begin
            for (int t = 0; t < 256; t++) begin
                for (int k = 0; k < LANES; k++) d[8*k +: 8] = 8'(t + 64 * k);
                send(2'(m), d, 4'(t), ref_xform(2'(m), d));
            end
        end
        // mode 11 on the mode-10 images must give back the original bytes
        for (int t = 0; t < 256; t++) begin
            for (int k = 0; k < LANES; k++) begin
                x = 8'(t + 64 * k);
                din[8*k +: 8]  = phi[x];
                dexp[8*k +: 8] = x;
            end
            send(2'b11, din, 4'(t), dexp);
        end
        drain();

        // back-to-back burst with a 5-cycle output stall
        sent = 0;
        for (int i = 0; i < 60 && (sent < 10 || sb_q.size() > 0); i++) begin
            ordy = !(i >= 4 && i < 9);
            d = $urandom;
            if (sent < 10) drive(1'b1, 2'b00, d, 4'(sent), ordy, ref_xform(2'b00, d), acc);
            else           drive(1'b0, 2'b00, d, 4'(sent), ordy, '0, acc);
            if (acc) sent++;
            if (i == 5 || i == 8) begin
                check("stall_occupancy", 64'(occupancy), 64'd3);
                check("stall_in_ready", 64'(in_ready), 64'd0);
                check("stall_out_valid", 64'(out_valid), 64'd1);
            end
        end
        check("stall_sent", 64'(sent), 64'd10);
        drain();

        // random traffic, mixed modes
        sent  = 0;
        guard = 0;
        while (sent < 10000 && guard < 60000) begin
            d = $urandom;
            x = 8'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), x[1:0], d, 4'($urandom), 1'($urandom_range(0, 1)),
                  ref_xform(x[1:0], d), acc);
            if (acc) sent++;
            guard++;
        end
        if (sent < 10000) timeout_fail("random_traffic");
        drain();

        // reset with a full pipeline
        guard = 0;
        while (occupancy != 2'd3 && guard < 20) begin
            d = $urandom;
            drive(1'b1, 2'b00, d, 4'h3, 1'b0, ref_xform(2'b00, d), acc);
            guard++;
        end
        check("pre_reset_occupancy", 64'(occupancy), 64'd3);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_occupancy", 64'(occupancy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            check("no_stale_output", 64'(out_valid), 64'd0);
        end
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
